// File: rtl/mips_irq_ctl_pkg.sv
// Shared definitions for the cop-bus interrupt controller: bus op codes,
// register offsets, FSM encodings and the vector address helper.
package mips_irq_ctl_pkg;

  localparam logic [3:0] DMEM_NOP = 4'd0;
  localparam logic [3:0] DMEM_LW  = 4'd1;
  localparam logic [3:0] DMEM_SW  = 4'd2;

  // Word index within the register window (byte offset >> 2)
  localparam logic [2:0] REG_PEND = 3'd0;
  localparam logic [2:0] REG_MASK = 3'd1;
  localparam logic [2:0] REG_ACK  = 3'd2;
  localparam logic [2:0] REG_CTRL = 3'd3;
  localparam logic [2:0] REG_EDGE = 3'd4;
  localparam logic [2:0] REG_CUR  = 3'd5;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  typedef struct packed {
    logic       rd;
    logic       wr;
    logic [2:0] idx;
  } bus_op_t;

  function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                           input logic [3:0]  id,
                                           input int          stride_log2);
    return base + ({28'd0, id} << stride_log2);
  endfunction

endpackage

// File: rtl/mips_irq_prio_enc.sv
// Lowest-index-wins priority encoder: valid when any request is set,
// id is the index of the lowest set bit.
module mips_irq_prio_enc #(
  parameter int N_SRC = 8
) (
  input  logic [N_SRC-1:0] req_i,
  output logic             valid_o,
  output logic [3:0]       id_o
);

  // Scan from the top down so the lowest set index is the last assignment.
  always_comb begin
    valid_o = 1'b0;
    id_o    = 4'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        valid_o = 1'b1;
        id_o    = 4'(i);
      end
    end
  end

endmodule

// File: rtl/mips_irq_ctl.sv
// Vectored fixed-priority interrupt controller on the cop bus: pend/mask
// register file, one request per interrupt, re-armed by an EOI write to CUR.
module mips_irq_ctl
  import mips_irq_ctl_pkg::*;
#(
  parameter int          N_SRC           = 8,
  parameter logic [31:0] BASE_ADDR       = 32'h8000_0100,
  parameter logic [31:0] VEC_BASE        = 32'h0000_0100,
  parameter int          VEC_STRIDE_LOG2 = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pause,
  input  logic [31:0]      addr,
  input  logic [31:0]      din,
  input  logic [3:0]       mem_ctl,
  output logic [31:0]      dout,
  input  logic [N_SRC-1:0] src_i,
  output logic             irq_req_o,
  output logic [31:0]      irq_addr_o
);

  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] edge_q, edge_d;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] src_prev_q;
  logic             ctrl_q, ctrl_d;
  logic [1:0]       state_q, state_d;
  logic [3:0]       cur_id_q, cur_id_d;
  logic [31:0]      irq_addr_q, irq_addr_d;
  logic [31:0]      dout_q, dout_d;

  bus_op_t          op;
  logic             win_hit;
  logic             eoi;
  logic [N_SRC-1:0] ack_clr;
  logic [N_SRC-1:0] eligible;
  logic             win_valid;
  logic [3:0]       win_id;
  logic [31:0]      rdata;
  logic             unused_din;

  assign unused_din = ^din;

  // The window is decoded on a 32-byte boundary; word offsets 6 and 7 are unmapped.
  assign win_hit = (addr[31:5] == BASE_ADDR[31:5]) && (addr[1:0] == 2'b00);
  assign op.rd   = win_hit && (mem_ctl == DMEM_LW);
  assign op.wr   = win_hit && (mem_ctl == DMEM_SW);
  assign op.idx  = addr[4:2];

  assign eoi     = op.wr && (op.idx == REG_CUR);
  assign ack_clr = (op.wr && (op.idx == REG_ACK)) ? din[N_SRC-1:0] : '0;

  always_comb begin
    mask_d = mask_q;
    edge_d = edge_q;
    ctrl_d = ctrl_q;
    if (op.wr) begin
      case (op.idx)
        REG_MASK: mask_d = din[N_SRC-1:0];
        REG_CTRL: ctrl_d = din[0];
        REG_EDGE: edge_d = din[N_SRC-1:0];
        default:  ;
      endcase
    end
  end

  // Edge bits latch until acknowledged (a new edge beats a same-cycle ACK);
  // level bits simply follow the source.
  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_pend
    assign pend_d[gi] = edge_q[gi]
                      ? ((pend_q[gi] & ~ack_clr[gi]) | (src_i[gi] & ~src_prev_q[gi]))
                      : src_i[gi];
  end

  assign eligible = pend_q & mask_q;

  mips_irq_prio_enc #(
    .N_SRC (N_SRC)
  ) u_prio_enc (
    .req_i   (eligible),
    .valid_o (win_valid),
    .id_o    (win_id)
  );

  always_comb begin
    state_d    = state_q;
    irq_addr_d = irq_addr_q;
    cur_id_d   = cur_id_q;
    case (state_q)
      ST_IDLE: begin
        if (ctrl_q && win_valid) begin
          state_d    = ST_REQ;
          irq_addr_d = vec_addr(VEC_BASE, win_id, VEC_STRIDE_LOG2);
          cur_id_d   = win_id;
        end
      end
      ST_REQ: begin
        if (!pause) state_d = ST_SERVICE;
      end
      ST_SERVICE: begin
        if (eoi) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rdata = 32'd0;
    case (op.idx)
      REG_PEND: rdata = 32'(pend_q);
      REG_MASK: rdata = 32'(mask_q);
      REG_CTRL: rdata = {31'd0, ctrl_q};
      REG_EDGE: rdata = 32'(edge_q);
      REG_CUR:  rdata = {(state_q != ST_IDLE), 27'd0, cur_id_q};
      default:  rdata = 32'd0;
    endcase
  end

  // Zero when not a read hit so dout can be OR-muxed with other cop devices.
  assign dout_d = op.rd ? rdata : 32'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q     <= '0;
      edge_q     <= '0;
      pend_q     <= '0;
      src_prev_q <= '0;
      ctrl_q     <= 1'b0;
      state_q    <= ST_IDLE;
      cur_id_q   <= 4'd0;
      irq_addr_q <= 32'd0;
      dout_q     <= 32'd0;
    end else begin
      mask_q     <= mask_d;
      edge_q     <= edge_d;
      pend_q     <= pend_d;
      src_prev_q <= src_i;
      ctrl_q     <= ctrl_d;
      state_q    <= state_d;
      cur_id_q   <= cur_id_d;
      irq_addr_q <= irq_addr_d;
      dout_q     <= dout_d;
    end
  end

  assign irq_req_o  = (state_q == ST_REQ);
  assign irq_addr_o = irq_addr_q;
  assign dout       = dout_q;

endmodule

// File: tb/tb_mips_irq_ctl.sv
// Directed bench for mips_irq_ctl: one task per scenario, inline checks.
module tb_mips_irq_ctl;
  import mips_irq_ctl_pkg::*;

  localparam logic [31:0] BASE = 32'h8000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        pause;
  logic [31:0] addr;
  logic [31:0] din;
  logic [3:0]  mem_ctl;
  logic [31:0] dout;
  logic [7:0]  src_i;
  logic        irq_req_o;
  logic [31:0] irq_addr_o;

  int errors = 0;
  int checks = 0;

  mips_irq_ctl dut (
    .clk        (clk),
    .rst        (rst),
    .pause      (pause),
    .addr       (addr),
    .din        (din),
    .mem_ctl    (mem_ctl),
    .dout       (dout),
    .src_i      (src_i),
    .irq_req_o  (irq_req_o),
    .irq_addr_o (irq_addr_o)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [7:0] off, input logic [31:0] data);
    addr    = BASE + {24'd0, off};
    din     = data;
    mem_ctl = DMEM_SW;
    step(1);
    mem_ctl = DMEM_NOP;
    din     = 32'd0;
    $display("write off=%02h data=%08h", off, data);
  endtask

  task automatic bus_read(input logic [7:0] off, output logic [31:0] data);
    addr    = BASE + {24'd0, off};
    mem_ctl = DMEM_LW;
    step(1);
    mem_ctl = DMEM_NOP;
    data    = dout;
    $display("read  off=%02h data=%08h", off, data);
  endtask

  task automatic test_reset;
    logic [31:0] r;
    rst = 1'b1;
    step(2);
    checks++;
    if (irq_req_o !== 1'b0 || irq_addr_o !== 32'd0 || dout !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: req=%b addr=%08h dout=%08h, required 0/0/0", irq_req_o, irq_addr_o, dout);
    end
    rst = 1'b0;
    step(1);
    bus_read(8'h14, r);
    checks++;
    if (r !== 32'd0) begin errors++; $display("FAIL reset_cur: got %08h required 00000000", r); end
  endtask

  task automatic test_regs;
    logic [31:0] r;
    bus_write(8'h04, 32'hFFFF_FFFF);
    bus_read(8'h04, r);
    checks++;
    if (r !== 32'h0000_00FF) begin errors++; $display("FAIL mask_width: got %08h required 000000ff", r); end
    bus_write(8'h10, 32'h1234_56A5);
    bus_read(8'h10, r);
    checks++;
    if (r !== 32'h0000_00A5) begin errors++; $display("FAIL edge_rw: got %08h required 000000a5", r); end
    bus_write(8'h0C, 32'h0000_0003);
    bus_read(8'h0C, r);
    checks++;
    if (r !== 32'h0000_0001) begin errors++; $display("FAIL ctrl_rw: got %08h required 00000001", r); end
    bus_write(8'h18, 32'h0000_0000);
    bus_read(8'h04, r);
    checks++;
    if (r !== 32'h0000_00FF) begin errors++; $display("FAIL unmapped_write: mask got %08h required 000000ff", r); end
    bus_read(8'h08, r);
    checks++;
    if (r !== 32'd0) begin errors++; $display("FAIL ack_read: got %08h required 00000000", r); end
    step(1);
    checks++;
    if (dout !== 32'd0) begin errors++; $display("FAIL dout_idle: got %08h required 00000000", dout); end
    bus_write(8'h0C, 32'd0);
    bus_write(8'h04, 32'd0);
    bus_write(8'h10, 32'd0);
  endtask

  task automatic test_global_enable;
    int hi = 0;
    bus_write(8'h04, 32'hFF);
    bus_write(8'h10, 32'hFF);
    src_i = 8'h02;
    step(1);
    src_i = 8'h00;
    for (int c = 0; c < 3; c++) begin
      if (irq_req_o) hi++;
      step(1);
    end
    checks++;
    if (hi !== 0) begin errors++; $display("FAIL ctrl_gate: %0d request cycles with CTRL=0, required 0", hi); end
    bus_write(8'h0C, 32'd1);
    step(1);
    checks++;
    if (irq_req_o !== 1'b1 || irq_addr_o !== 32'h108) begin
      errors++;
      $display("FAIL ctrl_enable: req=%b addr=%08h, required 1/00000108", irq_req_o, irq_addr_o);
    end
    step(1);
    bus_write(8'h08, 32'h02);
    bus_write(8'h14, 32'd0);
    step(2);
  endtask

  task automatic test_single_edge;
    logic [31:0] r;
    bus_write(8'h04, 32'h04);
    bus_write(8'h0C, 32'h01);
    bus_write(8'h10, 32'h04);
    src_i = 8'h04;
    step(1);
    src_i = 8'h00;
    checks++;
    if (irq_req_o !== 1'b0) begin errors++; $display("FAIL edge_early: req=%b at t+1, required 0", irq_req_o); end
    step(1);
    checks++;
    if (irq_req_o !== 1'b1 || irq_addr_o !== 32'h110) begin
      errors++;
      $display("FAIL edge_req: req=%b addr=%08h at t+2, required 1/00000110", irq_req_o, irq_addr_o);
    end
    step(1);
    checks++;
    if (irq_req_o !== 1'b0) begin errors++; $display("FAIL edge_one_shot: req=%b at t+3, required 0", irq_req_o); end
    bus_read(8'h14, r);
    checks++;
    if (r !== 32'h8000_0002) begin errors++; $display("FAIL edge_cur: got %08h required 80000002", r); end
    bus_write(8'h08, 32'h04);
    bus_write(8'h14, 32'd0);
    step(2);
    checks++;
    if (irq_req_o !== 1'b0) begin errors++; $display("FAIL edge_after_eoi: req=%b required 0", irq_req_o); end
    bus_read(8'h14, r);
    checks++;
    if (r !== 32'h0000_0002) begin errors++; $display("FAIL cur_idle: got %08h required 00000002", r); end
  endtask

  task automatic test_priority;
    logic [31:0] r;
    bus_write(8'h04, 32'hFF);
    bus_write(8'h10, 32'hFF);
    src_i = 8'h22;
    step(1);
    src_i = 8'h00;
    step(1);
    checks++;
    if (irq_req_o !== 1'b1 || irq_addr_o !== 32'h108) begin
      errors++;
      $display("FAIL prio_first: req=%b addr=%08h, required 1/00000108", irq_req_o, irq_addr_o);
    end
    step(1);
    bus_read(8'h00, r);
    checks++;
    if (r !== 32'h22) begin errors++; $display("FAIL prio_pend_both: got %08h required 00000022", r); end
    bus_write(8'h08, 32'h02);
    bus_read(8'h00, r);
    checks++;
    if (r !== 32'h20) begin errors++; $display("FAIL prio_pend_ack1: got %08h required 00000020", r); end
    bus_write(8'h14, 32'd0);
    step(1);
    checks++;
    if (irq_req_o !== 1'b1 || irq_addr_o !== 32'h128) begin
      errors++;
      $display("FAIL prio_second: req=%b addr=%08h, required 1/00000128", irq_req_o, irq_addr_o);
    end
    step(1);
    bus_read(8'h00, r);
    checks++;
    if (r !== 32'h20) begin errors++; $display("FAIL prio_pend_bit5: got %08h required 00000020", r); end
    bus_write(8'h08, 32'h20);
    bus_read(8'h00, r);
    checks++;
    if (r !== 32'h00) begin errors++; $display("FAIL prio_pend_clear: got %08h required 00000000", r); end
    bus_write(8'h14, 32'd0);
    step(2);
    checks++;
    if (irq_req_o !== 1'b0) begin errors++; $display("FAIL prio_quiet: req=%b required 0", irq_req_o); end
  endtask

  task automatic test_pause;
    int hi = 0;
    src_i = 8'h40;
    step(1);
    src_i = 8'h00;
    pause = 1'b1;
    step(1);
    for (int c = 0; c < 10; c++) begin
      if (c == 4) pause = 1'b0;
      if (irq_req_o) hi++;
      step(1);
    end
    checks++;
    if (hi !== 5) begin errors++; $display("FAIL pause_hold: %0d request cycles, required 5", hi); end
    checks++;
    if (irq_addr_o !== 32'h130) begin errors++; $display("FAIL pause_vec: got %08h required 00000130", irq_addr_o); end
    bus_write(8'h08, 32'h40);
    bus_write(8'h14, 32'd0);
    step(2);
  endtask

  task automatic test_level;
    int hi = 0;
    bus_write(8'h10, 32'h00);
    bus_write(8'h04, 32'h00);
    src_i = 8'h08;
    for (int c = 0; c < 3; c++) begin
      if (irq_req_o) hi++;
      step(1);
    end
    checks++;
    if (hi !== 0) begin errors++; $display("FAIL level_masked: %0d request cycles, required 0", hi); end
    bus_write(8'h04, 32'h08);
    step(1);
    checks++;
    if (irq_req_o !== 1'b1 || irq_addr_o !== 32'h118) begin
      errors++;
      $display("FAIL level_req: req=%b addr=%08h, required 1/00000118", irq_req_o, irq_addr_o);
    end
    step(1);
    bus_write(8'h14, 32'd0);
    step(1);
    checks++;
    if (irq_req_o !== 1'b1 || irq_addr_o !== 32'h118) begin
      errors++;
      $display("FAIL level_rereq: req=%b addr=%08h, required 1/00000118", irq_req_o, irq_addr_o);
    end
    step(1);
    src_i = 8'h00;
    step(1);
    bus_write(8'h14, 32'd0);
    step(2);
    checks++;
    if (irq_req_o !== 1'b0) begin errors++; $display("FAIL level_drop: req=%b required 0", irq_req_o); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] r;
    int hi = 0;
    int c;
    bus_write(8'h04, 32'hFF);
    bus_write(8'h10, 32'hFF);
    src_i = 8'h10;
    step(1);
    src_i = 8'h00;
    step(1);
    checks++;
    if (irq_addr_o !== 32'h120) begin errors++; $display("FAIL hold_first: addr=%08h required 00000120", irq_addr_o); end
    step(1);
    src_i = 8'h01;
    step(1);
    src_i = 8'h00;
    for (int k = 0; k < 3; k++) begin
      if (irq_req_o) hi++;
      step(1);
    end
    checks++;
    if (hi !== 0) begin errors++; $display("FAIL hold_no_preempt: %0d request cycles, required 0", hi); end
    bus_read(8'h14, r);
    checks++;
    if (r !== 32'h8000_0004) begin errors++; $display("FAIL hold_cur: got %08h required 80000004", r); end
    bus_write(8'h08, 32'h10);
    bus_write(8'h14, 32'd0);
    c = 0;
    while (!irq_req_o && c < 2) begin
      step(1);
      c++;
    end
    checks++;
    if (irq_req_o !== 1'b1 || irq_addr_o !== 32'h100) begin
      errors++;
      $display("FAIL hold_after_eoi: req=%b addr=%08h, required 1/00000100", irq_req_o, irq_addr_o);
    end
    step(1);
  endtask

  task automatic test_reset_mid_service;
    logic [31:0] r;
    logic [7:0]  offs [6];
    offs = '{8'h00, 8'h04, 8'h0C, 8'h10, 8'h14, 8'h18};
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    checks++;
    if (irq_req_o !== 1'b0 || irq_addr_o !== 32'd0) begin
      errors++;
      $display("FAIL rst_service: req=%b addr=%08h, required 0/00000000", irq_req_o, irq_addr_o);
    end
    foreach (offs[k]) begin
      bus_read(offs[k], r);
      checks++;
      if (r !== 32'd0) begin errors++; $display("FAIL rst_reg_%02h: got %08h required 00000000", offs[k], r); end
    end
  endtask

  initial begin
    rst     = 1'b1;
    pause   = 1'b0;
    addr    = 32'd0;
    din     = 32'd0;
    mem_ctl = DMEM_NOP;
    src_i   = 8'h00;
    test_reset;
    test_regs;
    test_global_enable;
    test_single_edge;
    test_priority;
    test_pause;
    test_level;
    test_back_to_back;
    test_reset_mid_service;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
